// File: rtl/hash_digest_writer.sv
// hash_digest_writer: sinks a valid/ready digest word stream into a single-port RAM,
// masking the unused tail bits of the last word and flagging writes beyond the RAM depth.
`default_nettype none

module hash_digest_writer #(
  parameter int IO_WIDTH      = 32,
  parameter int MAX_RAM_DEPTH = 4,
  parameter int ADDR_WIDTH    = $clog2(MAX_RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [IO_WIDTH-1:0]   i_output_length,
  input  logic [IO_WIDTH-1:0]   i_data_in,
  input  logic                  i_data_in_valid,
  output logic                  o_data_in_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [IO_WIDTH-1:0]   o_wr_data,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic                  o_done
);

  localparam int TAIL_W = $clog2(IO_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [IO_WIDTH-1:0] len_q;
  logic [IO_WIDTH-1:0] word_cnt;
  logic [IO_WIDTH-1:0] word_total;
  logic [IO_WIDTH:0]   len_round;
  logic [TAIL_W-1:0]   tail;
  logic [IO_WIDTH-1:0] tail_mask;
  logic                handshake;
  logic                last_word;
  logic                in_range;
  logic                start_ok;

  // One extra bit so a length near 2^IO_WIDTH does not wrap while rounding up.
  assign len_round  = {1'b0, len_q} + (IO_WIDTH+1)'(IO_WIDTH - 1);
  assign word_total = IO_WIDTH'(len_round >> TAIL_W);
  assign tail       = len_q[TAIL_W-1:0];
  assign tail_mask  = (tail == '0) ? '1 : ~({IO_WIDTH{1'b1}} >> tail);

  assign handshake  = i_data_in_valid & o_data_in_ready;
  assign last_word  = (word_cnt == word_total - IO_WIDTH'(1));
  assign in_range   = (word_cnt < IO_WIDTH'(MAX_RAM_DEPTH));
  assign start_ok   = (state == IDLE) & i_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_start) state_next = (i_output_length == '0) ? DONE : RUN;
      RUN:  if (handshake && last_word) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_data_in_ready = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      word_cnt   <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_wr_en <= handshake & in_range;
      o_busy  <= (state_next != IDLE);
      o_done  <= (state == DONE);
      if (handshake && in_range) begin
        o_wr_addr <= word_cnt[ADDR_WIDTH-1:0];
        o_wr_data <= last_word ? (i_data_in & tail_mask) : i_data_in;
      end
      if (start_ok) begin
        len_q      <= i_output_length;
        word_cnt   <= '0;
        o_overflow <= 1'b0;
      end else if (handshake) begin
        word_cnt <= word_cnt + IO_WIDTH'(1);
        if (!in_range) o_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hash_digest_writer.sv
// Scoreboard bench for hash_digest_writer: stimulus pushes expected writes/done pulses,
// a negedge monitor pops and compares whenever the DUT writes or signals done.
`default_nettype none

module tb_hash_digest_writer;

  localparam int IO_WIDTH = 32;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [IO_WIDTH-1:0] out_len = '0;
  logic [IO_WIDTH-1:0] data_in = '0;
  logic                data_valid = 1'b0;
  logic                ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [IO_WIDTH-1:0] wr_data;
  logic                busy;
  logic                overflow;
  logic                done;

  typedef struct {
    bit            is_done;
    bit            adj;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_wr_cyc = -100;

  hash_digest_writer #(.IO_WIDTH(IO_WIDTH), .MAX_RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_output_length(out_len),
    .i_data_in(data_in), .i_data_in_valid(data_valid), .o_data_in_ready(ready),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy),
    .o_overflow(overflow), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic void push_wr(input int a, input logic [31:0] d, input bit adj);
    exp_t e;
    e.is_done = 1'b0; e.adj = adj; e.addr = AW'(a); e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(input bit adj);
    exp_t e;
    e.is_done = 1'b1; e.adj = adj; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endfunction

  // Monitor: every write and every done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h, none expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("write_kind", {31'd0, e.is_done}, 32'd0);
        check("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
        check("wr_data", wr_data, e.data);
        if (e.adj) check("wr_back_to_back", cyc - last_wr_cyc, 32'd1);
      end
      last_wr_cyc = cyc;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: done=1, none expected");
      end else begin
        e = exp_q.pop_front();
        check("done_kind", {31'd0, e.is_done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (e.adj) check("done_after_last_write", cyc - last_wr_cyc, 32'd1);
      end
    end
  end

  // Called 1ns after a rising edge; the pulse is sampled on the next edge.
  task automatic do_start(input logic [31:0] len);
    start = 1'b1; out_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one word and returns 1ns after the edge on which it was accepted.
  task automatic send(input logic [31:0] d);
    bit taken = 1'b0;
    data_in = d; data_valid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      if (ready) taken = 1'b1;
      @(posedge clk); #1;
    end
    if (!taken) begin
      total++; bad++;
      $display("FAIL send_timeout: ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 30 && busy; i++) idle_cycles(1);
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle_timeout: busy=1 expected 0");
    end
    idle_cycles(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
    check({tag, "_wr_addr"},  {30'd0, wr_addr},  32'd0);
    check({tag, "_wr_data"},  wr_data,           32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_ready"},    {31'd0, ready},    32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
  endtask

  initial begin
    #2 check_all_zero("reset");
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(1);

    // Full 128-bit digest, valid held high, unmodified data on consecutive cycles.
    for (int i = 0; i < 4; i++) push_wr(i, 32'hA0000000 + i, i != 0);
    push_done(1'b1);
    do_start(32'd128);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_in_run", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 4; i++) send(32'hA0000000 + i);
    data_valid = 1'b0;
    check("ready_after_last", {31'd0, ready}, 32'd0);
    wait_idle();
    check("no_overflow_128", {31'd0, overflow}, 32'd0);

    // len=100: W=4, T=4, only the top nibble of the last word survives.
    push_wr(0, 32'h11111111, 1'b0);
    push_wr(1, 32'h22222222, 1'b1);
    push_wr(2, 32'h33333333, 1'b1);
    push_wr(3, 32'hD0000000, 1'b1);
    push_done(1'b1);
    do_start(32'd100);
    send(32'h11111111); send(32'h22222222); send(32'h33333333); send(32'hDEADBEEF);
    data_valid = 1'b0;
    wait_idle();

    // len=40: W=2, T=8.
    push_wr(0, 32'hCAFEF00D, 1'b0);
    push_wr(1, 32'h12000000, 1'b1);
    push_done(1'b1);
    do_start(32'd40);
    send(32'hCAFEF00D); send(32'h12345678);
    data_valid = 1'b0;
    wait_idle();

    // len=64 with a two-cycle valid gap.
    push_wr(0, 32'h0BADF00D, 1'b0);
    push_wr(1, 32'h600DCAFE, 1'b0);
    push_done(1'b1);
    do_start(32'd64);
    send(32'h0BADF00D);
    data_valid = 1'b0;
    idle_cycles(2);
    send(32'h600DCAFE);
    data_valid = 1'b0;
    wait_idle();

    // len=192: six words accepted, only four written, overflow sticky past done.
    for (int i = 0; i < 4; i++) push_wr(i, 32'hB0000000 + i, i != 0);
    push_done(1'b0);
    do_start(32'd192);
    for (int i = 0; i < 5; i++) send(32'hB0000000 + i);
    check("overflow_after_5th", {31'd0, overflow}, 32'd1);
    send(32'hB0000005);
    data_valid = 1'b0;
    wait_idle();
    check("overflow_held", {31'd0, overflow}, 32'd1);
    idle_cycles(3);
    check("overflow_still_held", {31'd0, overflow}, 32'd1);

    // len=0 with stray valid: no ready, no writes, done right after start; clears overflow.
    push_done(1'b0);
    data_in = 32'hFFFFFFFF; data_valid = 1'b1;
    do_start(32'd0);
    check("overflow_cleared", {31'd0, overflow}, 32'd0);
    check("ready_len0", {31'd0, ready}, 32'd0);
    check("busy_len0", {31'd0, busy}, 32'd1);
    idle_cycles(1);
    check("done_len0", {31'd0, done}, 32'd1);
    data_valid = 1'b0;
    wait_idle();

    // A second start mid-run must not restart the address count.
    for (int i = 0; i < 4; i++) push_wr(i, 32'hC0000000 + i, 1'b0);
    push_done(1'b1);
    do_start(32'd128);
    send(32'hC0000000); send(32'hC0000001);
    data_valid = 1'b0;
    do_start(32'd32);
    send(32'hC0000002); send(32'hC0000003);
    data_valid = 1'b0;
    wait_idle();

    // Reset mid-run after two writes: everything clears, no done.
    push_wr(0, 32'hE0000000, 1'b0);
    push_wr(1, 32'hE0000001, 1'b1);
    do_start(32'd128);
    send(32'hE0000000); send(32'hE0000001);
    @(negedge clk); #1;
    data_valid = 1'b0;
    rst = 1'b0;
    #1 check_all_zero("midrun_reset");
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);

    // Fresh start writes from address 0.
    push_wr(0, 32'h55AA55AA, 1'b0);
    push_done(1'b1);
    do_start(32'd32);
    send(32'h55AA55AA);
    data_valid = 1'b0;
    wait_idle();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
